// File: rtl/lmsm_pkg.sv
// Shared types and helpers for the LM/SM multi-register sequencer.
package lmsm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned NREG   = 8;
  localparam logic [2:0]  REG_PC = 3'd7;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } lowest_t;

  function automatic lowest_t lowest_set(input logic [NREG-1:0] mask);
    lowest_t r;
    r = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (mask[i] && !r.valid) begin
        r.valid = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lmsm_seq_if.sv
// Data-memory port driven by the LM/SM sequencer (master) and served by memory (slave).
interface lmsm_seq_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lmsm_prio_enc.sv
// Lowest-set-bit encoder selecting the next register of the remaining mask.
module lmsm_prio_enc
  import lmsm_pkg::*;
(
  input  logic [NREG-1:0] mask,
  output logic [2:0]      idx,
  output logic            any
);

  lowest_t r;

  always_comb begin
    r   = lowest_set(mask);
    idx = r.idx;
    any = r.valid;
  end

endmodule

// File: rtl/lmsm_seq.sv
// LM/SM sequencer: one register per memory beat, ascending register order.
// Optional macro LMSM_SKIP_R7_EN drops R7 from the mask at latch time.
module lmsm_seq
  import lmsm_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned NREG      = 8,
  parameter int unsigned ADDR_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NREG-1:0]   reg_mask,
  output logic              busy,
  output logic              done,
  output logic              pc_loaded,
  output logic [2:0]        rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [2:0]        rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  lmsm_seq_if.master        mem
);

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [NREG-1:0]   mask_q,  mask_d;
  logic              pc_q,    pc_d;
  logic [NREG-1:0]   latch_mask;
  logic [2:0]        cur_idx;
  logic              cur_any;

  lmsm_prio_enc u_prio_enc (
    .mask (mask_q),
    .idx  (cur_idx),
    .any  (cur_any)
  );

  always_comb begin
`ifdef LMSM_SKIP_R7_EN
    latch_mask = reg_mask & ~(NREG'(1) << REG_PC);
`else
    latch_mask = reg_mask;
`endif
  end

  assign busy      = (state_q != IDLE);
  assign pc_loaded = pc_q;

  always_comb begin
    state_d       = state_q;
    store_d       = store_q;
    addr_d        = addr_q;
    mask_d        = mask_q;
    pc_d          = pc_q;
    done          = 1'b0;
    rf_rd_addr    = '0;
    rf_wr_en      = 1'b0;
    rf_wr_addr    = '0;
    rf_wr_data    = '0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          store_d = is_store;
          addr_d  = base_addr;
          mask_d  = latch_mask;
          pc_d    = 1'b0;
          state_d = XFER;
        end
      end

      XFER: begin
        if (!cur_any) begin
          state_d = DONE;
        end else begin
          mem.mem_req  = 1'b1;
          mem.mem_we   = store_q;
          mem.mem_addr = addr_q;
          if (store_q) begin
            rf_rd_addr    = cur_idx;
            mem.mem_wdata = rf_rd_data;
          end
          // A beat completing in the reset cycle must not reach the register file.
          if (mem.mem_ack && !rst) begin
            if (!store_q) begin
              rf_wr_en   = 1'b1;
              rf_wr_addr = cur_idx;
              rf_wr_data = mem.mem_rdata;
              if (cur_idx == REG_PC) pc_d = 1'b1;
            end
            mask_d = mask_q & ~(NREG'(1) << cur_idx);
            addr_d = addr_q + ADDR_W'(ADDR_STEP);
            if (mask_d == '0) state_d = DONE;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (rst) mem.mem_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      pc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_lmsm_seq.sv
// Scoreboard bench for lmsm_seq: randomized and directed LM/SM operations.
module tb_lmsm_seq;

  logic        clk = 1'b0;
  logic        rst, start, is_store;
  logic [15:0] base_addr;
  logic [7:0]  reg_mask;
  logic        busy, done, pc_loaded, rf_wr_en;
  logic [2:0]  rf_rd_addr, rf_wr_addr;
  logic [15:0] rf_rd_data, rf_wr_data;

  lmsm_seq_if #(.DATA_W(16), .ADDR_W(16)) mem_if ();

  lmsm_seq #(.DATA_W(16), .ADDR_W(16), .NREG(8), .ADDR_STEP(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .base_addr  (base_addr),
    .reg_mask   (reg_mask),
    .busy       (busy),
    .done       (done),
    .pc_loaded  (pc_loaded),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .mem        (mem_if)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] addr; logic we; logic [15:0] wdata;} mem_exp_t;
  typedef struct {logic [2:0] a; logic [15:0] d;} rf_exp_t;
  typedef struct {int cyc; logic pc;} done_exp_t;

  mem_exp_t  mem_q[$];
  rf_exp_t   rf_q[$];
  done_exp_t done_q[$];

  logic [15:0] rf_mem [8];
  logic [15:0] ref_rf [8];
  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  int wait_cycles = 0;
  int wcnt = 0;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  assign mem_if.mem_rdata = mem_val(mem_if.mem_addr);
  assign rf_rd_data       = rf_mem[rf_rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory responder: wait_cycles idle cycles before each ack; random ack noise while idle.
  initial begin
    mem_if.mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_if.mem_req === 1'b1) begin
        if (wcnt >= wait_cycles) begin
          mem_if.mem_ack = 1'b1;
          wcnt = 0;
        end else begin
          mem_if.mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_if.mem_ack = 1'($urandom_range(0, 1));
        wcnt = 0;
      end
    end
  end

  // Monitor: compares every DUT-presented event against the queue heads.
  initial begin
    mem_exp_t  me;
    rf_exp_t   re;
    done_exp_t de;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mem_if.mem_req === 1'b1) begin
          if (mem_q.size() == 0) check("mem_req_unexpected", 32'd1, 32'd0);
          else begin
            me = mem_q[0];
            check("mem_addr", 32'(mem_if.mem_addr), 32'(me.addr));
            check("mem_we", 32'(mem_if.mem_we), 32'(me.we));
            if (me.we) check("mem_wdata", 32'(mem_if.mem_wdata), 32'(me.wdata));
            if (mem_if.mem_ack === 1'b1) void'(mem_q.pop_front());
          end
        end
        if (rf_wr_en === 1'b1) begin
          rf_mem[rf_wr_addr] = rf_wr_data;
          if (rf_q.size() == 0) check("rf_wr_unexpected", 32'd1, 32'd0);
          else begin
            re = rf_q.pop_front();
            check("rf_wr_addr", 32'(rf_wr_addr), 32'(re.a));
            check("rf_wr_data", 32'(rf_wr_data), 32'(re.d));
          end
        end
        if (done === 1'b1) begin
          if (done_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
          else begin
            de = done_q.pop_front();
            check("done_cycle", 32'(cyc), 32'(de.cyc));
            check("pc_loaded", 32'(pc_loaded), 32'(de.pc));
            check("busy_at_done", 32'(busy), 32'd1);
          end
        end
      end
    end
  end

  // Reference model: expected beats derived from the mask, then the start pulse.
  task automatic issue(input logic st, input logic [15:0] base, input logic [7:0] mask,
                       input int w, input int max_beats);
    logic [7:0] m;
    logic [15:0] a;
    int k;
    logic pc;
    m = mask;
`ifdef LMSM_SKIP_R7_EN
    m[7] = 1'b0;
`endif
    k  = 0;
    pc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m[i] && k < max_beats) begin
        a = base + 16'(k);
        mem_q.push_back('{a, st, st ? ref_rf[i] : 16'h0});
        if (!st) begin
          rf_q.push_back('{3'(i), mem_val(a)});
          ref_rf[i] = mem_val(a);
          if (i == 7) pc = 1'b1;
        end
        k++;
      end
    end
    if (max_beats >= 8)
      done_q.push_back('{cyc + 1 + ((k == 0) ? 1 : k * (w + 1)), pc});
    wait_cycles = w;
    start     = 1'b1;
    is_store  = st;
    base_addr = base;
    reg_mask  = mask;
    @(posedge clk);
    #1;
    start     = 1'b0;
    is_store  = 1'($urandom_range(0, 1));
    base_addr = 16'($urandom);
    reg_mask  = 8'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (busy === 1'b0 && mem_q.size() == 0 && rf_q.size() == 0 && done_q.size() == 0) return;
      @(posedge clk);
      #1;
    end
    check("op_timeout", 32'd1, 32'd0);
    mem_q.delete();
    rf_q.delete();
    done_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    rst = 1'b1; start = 1'b0; is_store = 1'b0; base_addr = '0; reg_mask = '0;
    for (int i = 0; i < 8; i++) begin
      v = 16'($urandom);
      rf_mem[i] = v;
      ref_rf[i] = v;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pc_loaded", 32'(pc_loaded), 32'd0);
    check("rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
    check("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_if.mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_if.mem_wdata), 32'd0);
    check("rst_rf_wr_addr", 32'(rf_wr_addr), 32'd0);
    check("rst_rf_wr_data", 32'(rf_wr_data), 32'd0);
    check("rst_rf_rd_addr", 32'(rf_rd_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // LM two registers, zero-wait
    issue(1'b0, 16'h0100, 8'b0000_0101, 0, 8);
    wait_idle();

    // SM with address wrap
    rf_mem[1] = 16'hAAAA; ref_rf[1] = 16'hAAAA;
    rf_mem[7] = 16'h1234; ref_rf[7] = 16'h1234;
    issue(1'b1, 16'hFFFF, 8'b1000_0010, 0, 8);
    wait_idle();

    // LM full mask, 3 wait cycles per beat, stray start mid-transfer
    issue(1'b0, 16'h2000, 8'hFF, 3, 8);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; is_store = 1'b1; reg_mask = 8'h0F; base_addr = 16'h0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // Empty mask
    issue(1'b0, 16'h3000, 8'h00, 0, 8);
    wait_idle();

    // Reset after second beat of a 4-beat LM
    issue(1'b0, 16'h4000, 8'b0101_1010, 0, 2);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_mem_req", 32'(mem_if.mem_req), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_pc_loaded", 32'(pc_loaded), 32'd0);
    wait_idle();

    // Randomized operations
    for (int n = 0; n < 25; n++) begin
      issue(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), $urandom_range(0, 2), 8);
      wait_idle();
    end

    for (int i = 0; i < 8; i++) check("rf_final", 32'(rf_mem[i]), 32'(ref_rf[i]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lmsm_seq.md
Name: lmsm_seq

Overview:
Multi-register load/store sequencer for the LM/SM instructions. It is the initiator that drives the register file's read and write ports, one register per memory beat.
- LM: reads consecutive memory words and writes them into the registers selected by an 8-bit mask.
- SM: reads the selected registers and stores them to consecutive memory words.
The block sits between the decode/execute stage, the register file and the data-memory port. The pipeline stalls while `busy` is high.

Parameters:
- DATA_W, 16, register and memory data width.
- ADDR_W, 16, memory address width.
- NREG, 8, number of architectural registers (R0..R7, with R7 = PC); sets the mask width.
- ADDR_STEP, 1, address increment per transferred register (word addressing).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin; sampled only in IDLE.
- is_store  in  1  1 = SM, 0 = LM; latched at start.
- base_addr  in  ADDR_W  first memory address; latched at start.
- reg_mask  in  NREG  bit i set = transfer Ri; latched at start.
- busy  out  1  high from the cycle after an accepted start until the cycle after done.
- done  out  1  one-cycle completion pulse.
- pc_loaded  out  1  valid with done; 1 = an LM wrote R7.
- rf_rd_addr  out  3  register-file read address (SM).
- rf_rd_data  in  DATA_W  combinational read data for rf_rd_addr.
- rf_wr_en  out  1  register-file write strobe (LM).
- rf_wr_addr  out  3  register-file write address.
- rf_wr_data  out  DATA_W  register-file write data.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write (SM).
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  load data, valid with mem_ack.
- mem_ack  in  1  transfer complete; sampled at the rising edge.

Behaviour:
- Reset values: IDLE state; busy, done, pc_loaded, rf_wr_en, mem_req, mem_we = 0; all address and data outputs = 0. Latched mask = 0.
- States: IDLE, XFER, DONE.
- IDLE:
  - start=1 latches is_store, base_addr and reg_mask; the address counter is set to base_addr; next state is XFER.
  - A start while not in IDLE is ignored.
- XFER:
  - The current register is the lowest set bit of the remaining mask.
  - If the remaining mask is 0, next state is DONE with no memory access. This includes a mask of 0 at start.
  - Otherwise mem_req=1, mem_addr = counter, mem_we = is_store. For SM, rf_rd_addr = current register and mem_wdata = rf_rd_data.
  - All request outputs are held stable until mem_ack=1 is sampled.
  - Only one request is outstanding at a time.
  - An ack in the first cycle of a request is legal. mem_ack is ignored when mem_req=0.
- On ack:
  - LM: rf_wr_en=1 for exactly that cycle, with rf_wr_addr = current register and rf_wr_data = mem_rdata. This is combinational from the ack, so it lands in the same edge.
  - The current bit is cleared from the remaining mask and the counter advances by ADDR_STEP, wrapping modulo 2^ADDR_W.
  - mem_req may remain high for the next register with no idle cycle between beats.
  - Transfer order is ascending register index.
- DONE: done=1 for one cycle, then IDLE. busy drops in the IDLE cycle that follows.
- pc_loaded = 1 iff an LM wrote R7 during this operation. It is cleared at the next start.
- Throughput: N set bits with zero-wait ack gives 1 (start) + N + 1 (done) cycles. An empty mask takes 3 cycles from start to the return to IDLE.
- Reset mid-operation: IDLE at the next edge and mem_req=0. No further rf writes, no done pulse. Registers already written keep their values.
- rf_wr_en is never asserted for SM.

Optional Feature:
- Macro: LMSM_SKIP_R7_EN.
- When defined: mask bit 7 is forced to 0 at latch time. R7 is never transferred, pc_loaded stays 0, and the address sequence covers only R0..R6.
- When undefined: R7 is transferred like any other register; an LM into R7 asserts pc_loaded.

Decomposition:
- Package lmsm_pkg contains:
  - state enum {IDLE, XFER, DONE};
  - localparams NREG=8 and REG_PC=3'd7;
  - function lowest_set(mask) returning index and valid.
- One sub-module: lmsm_prio_enc, an 8-bit lowest-set-bit encoder with outputs idx[2:0] and any.

Test Plan:
- LM, mask 8'b0000_0101, base 16'h0100, immediate acks: mem reads at 0x0100 and 0x0101; R0 then R2 written with the returned data; done on cycle 4 after start; pc_loaded 0.
- SM, mask 8'b1000_0010, base 16'hFFFF, R1=16'hAAAA, R7=16'h1234: writes (0xFFFF, AAAA) then (0x0000, 1234), confirming address wrap; no rf_wr_en.
- LM with mem_ack delayed 3 cycles per beat, mask 8'hFF: mem_addr and mem_req stay stable while waiting; 8 rf writes in order R0..R7; pc_loaded=1. With LMSM_SKIP_R7_EN: 7 writes and pc_loaded=0.
- Mask 8'h00 start: no mem_req; done pulses exactly 2 cycles after start.
- Second start pulsed mid-XFER is ignored; rst asserted after the second beat of a 4-beat LM: mem_req=0 at the next edge, only 2 registers changed, no done pulse.
